// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side burst reader: default widths,
// FSM state encodings and a saturating counter helper.
package fifo_pkg;

   localparam int DSIZE_DEF = 16;
   localparam int LENW_DEF  = 8;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   // Increment that sticks at the top value instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == STALL_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer. The head entry is a register that
// drives out_data directly, so the output word is registered and holds
// while the consumer stalls.
module fifo_reader_skid
   import fifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [DSIZE-1:0] push_data,
   input  logic             pop,
   output logic [DSIZE-1:0] head,
   output logic [1:0]       count
);

   logic [DSIZE-1:0] entry1;

   // Storage and occupancy update; push is never issued at count 2 and
   // pop never at count 0, so those combinations need no handling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head   <= '0;
         entry1 <= '0;
         count  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               entry1 <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= entry1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Count stays the same; the incoming word lands behind
               // whatever is left after the head leaves.
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head   <= entry1;
                  entry1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_reader.sv
// Burst reader for a first-word-fall-through FIFO. A request for N words
// pops exactly N words, passes them through a 2-entry output buffer to a
// valid/ready consumer, pulses done at the end and counts empty stalls.
//
// Handshakes: a transfer happens on a rising rclk edge where valid and
// ready are both 1 (req_valid/req_ready, out_valid/out_ready); r_en is a
// pop strobe that consumes the FIFO head on the same edge.
module fifo_reader
   import fifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int LENW  = LENW_DEF
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             r_en,
   input  logic             req_valid,
   input  logic [LENW-1:0]  req_len,
   output logic             req_ready,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   input  logic             out_ready,
   output logic             done,
   output logic [15:0]      stall_cnt,
   output logic [1:0]       dbg_state
);

   logic [1:0]      state;
   logic [LENW-1:0] remaining;
   logic [1:0]      buf_count;
   logic            buf_pop;

   // Pop only when the buffer has room; out_ready plays no part here.
   always_comb begin
      r_en = (state == ST_BURST) && !rempty &&
             (remaining != '0) && (buf_count < 2'd2);
   end

   // Status outputs decoded from registered state.
   always_comb begin
      req_ready = (state == ST_IDLE);
      done      = (state == ST_DONE);
      out_valid = (buf_count != 2'd0);
      buf_pop   = out_valid && out_ready;
      dbg_state = state;
   end

   // Burst control FSM, remaining-word counter and stall counter.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         stall_cnt <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  remaining <= req_len;
                  stall_cnt <= 16'd0;
                  state     <= (req_len != '0) ? ST_BURST : ST_DONE;
               end
            end
            ST_BURST: begin
               if (r_en) begin
                  remaining <= remaining - LENW'(1);
                  if (remaining == LENW'(1)) state <= ST_DRAIN;
               end
               if ((remaining != '0) && rempty) stall_cnt <= sat_inc(stall_cnt);
            end
            ST_DRAIN: begin
               // Leave once the buffer is empty or its last word goes out.
               if ((buf_count == 2'd0) || ((buf_count == 2'd1) && buf_pop))
                  state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   fifo_reader_skid #(.DSIZE(DSIZE)) u_skid (
      .clk       (rclk),
      .rst       (rrst),
      .push      (r_en),
      .push_data (rdata),
      .pop       (buf_pop),
      .head      (out_data),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO model feeds the DUT, a
// scoreboard holds the words each burst must deliver, and a table of
// burst scenarios plus random bursts and an async-reset sequence run.
module tb_fifo_reader;
   import fifo_pkg::*;

   localparam int DSIZE = 16;
   localparam int LENW  = 8;

   logic             rclk = 1'b0;
   logic             rrst;
   logic             rempty;
   logic [DSIZE-1:0] rdata;
   logic             r_en;
   logic             req_valid;
   logic [LENW-1:0]  req_len;
   logic             req_ready;
   logic             out_valid;
   logic [DSIZE-1:0] out_data;
   logic             out_ready;
   logic             done;
   logic [15:0]      stall_cnt;
   logic [1:0]       dbg_state;

   fifo_reader #(.DSIZE(DSIZE), .LENW(LENW)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rempty    (rempty),
      .rdata     (rdata),
      .r_en      (r_en),
      .req_valid (req_valid),
      .req_len   (req_len),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .done      (done),
      .stall_cnt (stall_cnt),
      .dbg_state (dbg_state)
   );

   // clock
   always #5 rclk = ~rclk;

   typedef struct {
      int preload;    // words in the FIFO before the request
      int len;        // burst length
      int late_n;     // words written later
      int late_delay; // cycle (after acceptance) of the late write
      int rdy_hold;   // cycles of out_ready=0 at the start
      int ready_pct;  // out_ready probability afterwards
      bit hold;       // keep req_valid high through the burst
      int exp_left;   // words left in the FIFO afterwards
      int stall_min;  // lower bound on stall_cnt
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DSIZE-1:0] fifo_q[$];
   logic [DSIZE-1:0] exp_q[$];

   task automatic check(input string name, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fifo_drive();
      rempty = (fifo_q.size() == 0);
      rdata  = rempty ? 16'hDEAD : fifo_q[0];
   endtask

   // One clock: the sampled pop consumes the model FIFO head.
   task automatic advance(input bit pop);
      @(posedge rclk);
      #1;
      if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_drive();
   endtask

   task automatic run_burst(input vec_t v, input bit rand_words);
      logic [DSIZE-1:0] late_w[$];
      logic [DSIZE-1:0] prev_data;
      bit acc, seen_done, prev_hold, pop_s, acc_s;
      int pops, accs, last_acc, stall_m, occ;
      fifo_q.delete();
      exp_q.delete();
      late_w.delete();
      for (int i = 0; i < v.preload; i++)
         fifo_q.push_back(rand_words ? DSIZE'($urandom) : DSIZE'(16'hA000 + i));
      for (int i = 0; i < v.late_n; i++)
         late_w.push_back(rand_words ? DSIZE'($urandom) : DSIZE'(16'hB000 + i));
      for (int i = 0; i < v.len; i++)
         exp_q.push_back((i < v.preload) ? fifo_q[i] : late_w[i - v.preload]);
      fifo_drive();
      out_ready = 1'b0;
      req_valid = 1'b1;
      req_len   = LENW'(v.len);
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
         @(negedge rclk);
         acc = req_ready;
         check("idle_r_en", r_en, 0);
         advance(1'b0);
      end
      check("req_accept", acc, 1);
      if (v.hold) req_len = LENW'(v.len + 5);
      else        req_valid = 1'b0;
      pops = 0; accs = 0; last_acc = -1; stall_m = 0;
      seen_done = 1'b0; prev_hold = 1'b0; prev_data = '0;
      for (int cyc = 1; cyc <= 2000 && !seen_done; cyc++) begin
         out_ready = (cyc <= v.rdy_hold) ? 1'b0 : ($urandom_range(99) < v.ready_pct);
         if (cyc == v.late_delay) begin
            foreach (late_w[i]) fifo_q.push_back(late_w[i]);
            fifo_drive();
         end
         @(negedge rclk);
         occ = pops - accs;
         check("out_valid_occ", out_valid, occ != 0);
         if (out_valid && accs < v.len) check("out_data", out_data, exp_q[accs]);
         if (prev_hold) check("stable_data", out_data, prev_data);
         if (r_en) begin
            check("r_en_when_empty", rempty, 0);
            check("r_en_buf_room", occ < 2, 1);
            check("r_en_over_read", pops < v.len, 1);
         end
         if (v.hold) check("req_ready_busy", req_ready, 0);
         if (pops < v.len && rempty && stall_m < 65535) stall_m++;
         if (done) begin
            seen_done = 1'b1;
            check("done_pops", pops, v.len);
            check("done_accs", accs, v.len);
            if (v.len == 0) check("done_latency_len0", cyc, 1);
            else            check("done_after_last", last_acc, cyc - 1);
            check("stall_cnt", stall_cnt, stall_m);
            check("stall_min", stall_cnt >= 16'(v.stall_min), 1);
         end
         pop_s     = r_en;
         acc_s     = out_valid && out_ready;
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         advance(pop_s);
         pops += int'(pop_s);
         if (acc_s) begin
            accs++;
            last_acc = cyc;
         end
      end
      req_valid = 1'b0;
      check("done_seen", seen_done, 1);
      for (int k = 0; k < 2; k++) begin
         @(negedge rclk);
         check("post_done", done, 0);
         check("post_r_en", r_en, 0);
         check("post_req_ready", req_ready, 1);
         check("stall_hold", stall_cnt, stall_m);
         advance(1'b0);
      end
      check("fifo_left", fifo_q.size(), v.exp_left);
   endtask

   initial begin
      vec_t vecs[6];
      vec_t rv;
      int hold_cyc;
      bit pop_s;

      // reset block
      rrst = 1'b1; req_valid = 1'b0; req_len = '0; out_ready = 1'b0;
      fifo_q.delete();
      fifo_drive();
      #1;
      check("rst_r_en", r_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall_cnt, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_state", dbg_state, ST_IDLE);
      @(posedge rclk); @(posedge rclk); #1;
      rrst = 1'b0;

      vecs[0] = '{4, 3, 0, 0, 0, 100, 1'b0, 1, 0};   // A0..A2 out, A3 left
      vecs[1] = '{4, 6, 2, 14, 0, 100, 1'b0, 0, 9};  // stall while empty
      vecs[2] = '{4, 4, 0, 0, 8, 100, 1'b0, 0, 0};   // consumer blocked first
      vecs[3] = '{2, 0, 0, 0, 0, 100, 1'b0, 2, 0};   // zero-length burst
      vecs[4] = '{3, 3, 0, 0, 0, 100, 1'b1, 0, 0};   // req_valid held high
      vecs[5] = '{4, 2, 0, 0, 0, 50, 1'b0, 2, 0};    // random backpressure
      for (int i = 0; i < 6; i++) run_burst(vecs[i], 1'b0);

      // back-to-back held request: second burst taken after the first done
      run_burst(vecs[4], 1'b1);

      // random bursts
      for (int i = 0; i < 20; i++) begin
         rv.preload    = $urandom_range(4);
         rv.len        = $urandom_range(rv.preload + 4);
         rv.late_n     = (rv.len > rv.preload) ? rv.len - rv.preload + $urandom_range(1) : 0;
         rv.late_delay = $urandom_range(15, 1);
         rv.rdy_hold   = $urandom_range(3);
         rv.ready_pct  = $urandom_range(100, 30);
         rv.hold       = 1'(($urandom_range(3) == 0) && (rv.len != 0));
         rv.exp_left   = rv.preload + rv.late_n - rv.len;
         rv.stall_min  = 0;
         run_burst(rv, 1'b1);
      end

      // asynchronous reset in the middle of a burst
      fifo_q.delete();
      for (int i = 0; i < 4; i++) fifo_q.push_back(DSIZE'(16'hC000 + i));
      fifo_drive();
      out_ready = 1'b0; req_valid = 1'b1; req_len = LENW'(4);
      @(negedge rclk);
      check("mid_accept", req_ready, 1);
      advance(1'b0);
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge rclk);
         pop_s = r_en;
         advance(pop_s);
      end
      @(negedge rclk);
      check("mid_pre_valid", out_valid, 1);
      #2 rrst = 1'b1;
      #1;
      check("mid_rst_r_en", r_en, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_stall", stall_cnt, 0);
      check("mid_rst_ready", req_ready, 1);
      @(posedge rclk); #1;
      rrst = 1'b0;
      out_ready = 1'b1;
      hold_cyc = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge rclk);
         check("post_rst_r_en", r_en, 0);
         check("post_rst_valid", out_valid, 0);
         hold_cyc += int'(r_en);
         advance(r_en);
      end
      check("post_rst_pops", hold_cyc, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
